// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencer for the pipelined core.
// Owns PC, EPC and the EXL flag, arbitrates soft reset, exceptions, eret,
// jr, j, taken branches and sequential fetch, and drives flush/fetch-enable.
// Optional feature macro: PC_SEQ_PERF_EN adds saturating redirect and stall
// counters; without it o_redirect_cnt and o_stall_cnt are tied to zero.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_000C,
    parameter int unsigned EXC_DRAIN_CYC = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_s_rst,
    input  logic        i_beq,
    input  logic        i_bne,
    input  logic        i_zero,
    input  logic        i_j,
    input  logic        i_jr,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_pc_4_dec,
    input  logic        i_exc_req,
    input  logic [31:0] i_exc_pc,
    input  logic        i_eret,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_4,
    output logic        o_fetch_en,
    output logic        o_flush_if,
    output logic        o_flush_id,
    output logic        o_flush_ex,
    output logic [31:0] o_epc,
    output logic        o_exl,
    output logic        o_exc_drop,
    output logic [1:0]  o_state,
    output logic [15:0] o_redirect_cnt,
    output logic [15:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        EXC_DRAIN = 2'd2,
        SRST      = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(EXC_DRAIN_CYC);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic [31:0] epc_next;
    logic        exl;
    logic        exl_next;
    logic [3:0]  drain;
    logic [3:0]  drain_next;

    logic        taken;
    logic        jr_bad;
    logic        exc_hit;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // A misaligned jr only counts as a fault when the jr is really executing
    // (not held by a stall); an older execute-stage fault shares the same path.
    assign taken     = (i_beq & i_zero) | (i_bne & ~i_zero);
    assign jr_bad    = i_jr & ~i_stall & (i_rs[1:0] != 2'b00);
    assign exc_hit   = i_exc_req | jr_bad;
    assign br_target = i_pc_4_dec + {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
    assign j_target  = {i_pc_4_dec[31:28], i_imm26, 2'b00};

    // Next-state, next-PC and squash decision for the current cycle.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        epc_next   = epc;
        exl_next   = exl;
        drain_next = drain;
        o_flush_if = 1'b0;
        o_flush_id = 1'b0;
        o_flush_ex = 1'b0;
        o_exc_drop = 1'b0;
        case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (i_s_rst) begin
                    state_next = SRST;
                    o_flush_if = 1'b1;
                    o_flush_id = 1'b1;
                    o_flush_ex = 1'b1;
                end else if (exc_hit && !exl) begin
                    pc_next    = EXC_VECTOR;
                    epc_next   = i_exc_req ? i_exc_pc : (i_pc_4_dec - 32'd4);
                    exl_next   = 1'b1;
                    drain_next = DRAIN_LOAD;
                    state_next = EXC_DRAIN;
                    o_flush_if = 1'b1;
                    o_flush_id = 1'b1;
                    o_flush_ex = 1'b1;
                end else begin
                    o_exc_drop = exc_hit;
                    if (i_eret && exl) begin
                        pc_next    = epc;
                        exl_next   = 1'b0;
                        o_flush_if = 1'b1;
                    end else if (i_stall) begin
                        pc_next = pc;
                    end else if (i_jr && !jr_bad) begin
                        pc_next    = i_rs;
                        o_flush_if = 1'b1;
                    end else if (i_j) begin
                        pc_next    = j_target;
                        o_flush_if = 1'b1;
                    end else if (taken) begin
                        pc_next    = br_target;
                        o_flush_if = 1'b1;
                    end else begin
                        pc_next = pc + 32'd4;
                    end
                end
            end
            EXC_DRAIN: begin
                o_exc_drop = i_exc_req;
                if (drain <= 4'd1) begin
                    drain_next = 4'd0;
                    state_next = RUN;
                end else begin
                    drain_next = drain - 4'd1;
                end
            end
            SRST: begin
                if (i_s_rst) begin
                    o_flush_if = 1'b1;
                    o_flush_id = 1'b1;
                    o_flush_ex = 1'b1;
                end else begin
                    pc_next    = RESET_PC;
                    exl_next   = 1'b0;
                    state_next = BOOT;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Architectural state registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
            epc   <= 32'd0;
            exl   <= 1'b0;
            drain <= 4'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            epc   <= epc_next;
            exl   <= exl_next;
            drain <= drain_next;
        end
    end

    assign o_pc       = pc;
    assign o_pc_4     = pc + 32'd4;
    assign o_epc      = epc;
    assign o_exl      = exl;
    assign o_state    = state;
    assign o_fetch_en = (state == RUN);

`ifdef PC_SEQ_PERF_EN
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;
    logic        redirect;
    logic        stall_cycle;
    logic        srst_release;

    assign redirect     = (state == RUN) & ~i_s_rst & o_flush_if;
    assign stall_cycle  = (state == RUN) & i_stall;
    assign srst_release = (state == SRST) & ~i_s_rst;

    // Saturating performance counters, cleared on reset and soft-reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_cnt <= 16'd0;
            stall_cnt    <= 16'd0;
        end else if (srst_release) begin
            redirect_cnt <= 16'd0;
            stall_cnt    <= 16'd0;
        end else begin
            if (redirect && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
            if (stall_cycle && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign o_redirect_cnt = redirect_cnt;
    assign o_stall_cnt    = stall_cnt;
`else
    assign o_redirect_cnt = 16'd0;
    assign o_stall_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: self-checking bench for pc_seq_ctrl (default build).
// Directed vector table, hand-written multi-cycle sequences and a random
// phase, all shadowed by a behavioural model of the sequencing rules.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_000C;
    localparam int          DRAIN      = 2;

    typedef struct packed {
        logic        stall;
        logic        s_rst;
        logic        beq;
        logic        bne;
        logic        zero;
        logic        j;
        logic        jr;
        logic        exc_req;
        logic        eret;
        logic [25:0] imm26;
        logic [31:0] rs;
        logic [31:0] pc4dec;
        logic [31:0] exc_pc;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] exp_pc;
        logic        exp_fif;
    } vec_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_s_rst;
    logic        i_beq;
    logic        i_bne;
    logic        i_zero;
    logic        i_j;
    logic        i_jr;
    logic [25:0] i_imm26;
    logic [31:0] i_rs;
    logic [31:0] i_pc_4_dec;
    logic        i_exc_req;
    logic [31:0] i_exc_pc;
    logic        i_eret;
    logic [31:0] o_pc;
    logic [31:0] o_pc_4;
    logic        o_fetch_en;
    logic        o_flush_if;
    logic        o_flush_id;
    logic        o_flush_ex;
    logic [31:0] o_epc;
    logic        o_exl;
    logic        o_exc_drop;
    logic [1:0]  o_state;
    logic [15:0] o_redirect_cnt;
    logic [15:0] o_stall_cnt;

    int errors = 0;
    int checks = 0;

    // behavioural model: mode 0=BOOT 1=RUN 2=EXC_DRAIN 3=SRST
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_exl;
    int          m_left;
    int          n_mode;
    logic [31:0] n_pc;
    logic [31:0] n_epc;
    logic        n_exl;
    int          n_left;
    logic        e_fif, e_fid, e_fex, e_drop;

    logic        cap_fif, cap_fid, cap_fex, cap_drop;

    vec_t        vecs[14];

    pc_seq_ctrl dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_stall        (i_stall),
        .i_s_rst        (i_s_rst),
        .i_beq          (i_beq),
        .i_bne          (i_bne),
        .i_zero         (i_zero),
        .i_j            (i_j),
        .i_jr           (i_jr),
        .i_imm26        (i_imm26),
        .i_rs           (i_rs),
        .i_pc_4_dec     (i_pc_4_dec),
        .i_exc_req      (i_exc_req),
        .i_exc_pc       (i_exc_pc),
        .i_eret         (i_eret),
        .o_pc           (o_pc),
        .o_pc_4         (o_pc_4),
        .o_fetch_en     (o_fetch_en),
        .o_flush_if     (o_flush_if),
        .o_flush_id     (o_flush_id),
        .o_flush_ex     (o_flush_ex),
        .o_epc          (o_epc),
        .o_exl          (o_exl),
        .o_exc_drop     (o_exc_drop),
        .o_state        (o_state),
        .o_redirect_cnt (o_redirect_cnt),
        .o_stall_cnt    (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        i_stall    = s.stall;
        i_s_rst    = s.s_rst;
        i_beq      = s.beq;
        i_bne      = s.bne;
        i_zero     = s.zero;
        i_j        = s.j;
        i_jr       = s.jr;
        i_exc_req  = s.exc_req;
        i_eret     = s.eret;
        i_imm26    = s.imm26;
        i_rs       = s.rs;
        i_pc_4_dec = s.pc4dec;
        i_exc_pc   = s.exc_pc;
    endtask

    function automatic stim_t mk(input logic stall, input logic beq, input logic bne, input logic zero,
                                 input logic j, input logic jr, input logic eret, input logic [25:0] imm,
                                 input logic [31:0] rs, input logic [31:0] pc4);
        stim_t s;
        s        = '0;
        s.stall  = stall;
        s.beq    = beq;
        s.bne    = bne;
        s.zero   = zero;
        s.j      = j;
        s.jr     = jr;
        s.eret   = eret;
        s.imm26  = imm;
        s.rs     = rs;
        s.pc4dec = pc4;
        return s;
    endfunction

    task automatic modelReset();
        m_mode = 0;
        m_pc   = RESET_PC;
        m_epc  = 32'd0;
        m_exl  = 1'b0;
        m_left = 0;
    endtask

    // Sequencing rules: what this cycle squashes and where the PC goes next.
    task automatic modelCycle(input stim_t s);
        logic misjr;
        logic fault;
        int   off;
        n_mode = m_mode; n_pc = m_pc; n_epc = m_epc; n_exl = m_exl; n_left = m_left;
        e_fif = 0; e_fid = 0; e_fex = 0; e_drop = 0;
        if (m_mode == 0) begin
            n_mode = 1;
        end else if (m_mode == 1) begin
            misjr = s.jr && !s.stall && (s.rs % 4 != 0);
            fault = s.exc_req || misjr;
            off   = int'($signed(s.imm26[15:0])) * 4;
            if (s.s_rst) begin
                n_mode = 3; e_fif = 1; e_fid = 1; e_fex = 1;
            end else if (fault && !m_exl) begin
                n_mode = 2; n_left = DRAIN; n_pc = EXC_VECTOR; n_exl = 1;
                n_epc = s.exc_req ? s.exc_pc : s.pc4dec - 32'd4;
                e_fif = 1; e_fid = 1; e_fex = 1;
            end else begin
                e_drop = fault;
                if (s.eret && m_exl) begin
                    n_pc = m_epc; n_exl = 0; e_fif = 1;
                end else if (s.stall) begin
                    n_pc = m_pc;
                end else if (s.jr && !misjr) begin
                    n_pc = s.rs; e_fif = 1;
                end else if (s.j) begin
                    n_pc = (s.pc4dec & 32'hF000_0000) | (32'(s.imm26) * 4); e_fif = 1;
                end else if ((s.beq && s.zero) || (s.bne && !s.zero)) begin
                    n_pc = s.pc4dec + 32'(off); e_fif = 1;
                end else begin
                    n_pc = m_pc + 32'd4;
                end
            end
        end else if (m_mode == 2) begin
            e_drop = s.exc_req;
            n_left = m_left - 1;
            if (n_left == 0) n_mode = 1;
        end else begin
            if (s.s_rst) begin
                e_fif = 1; e_fid = 1; e_fex = 1;
            end else begin
                n_mode = 0; n_pc = RESET_PC; n_exl = 0;
            end
        end
    endtask

    task automatic modelCommit();
        m_mode = n_mode; m_pc = n_pc; m_epc = n_epc; m_exl = n_exl; m_left = n_left;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".pc"},    o_pc,       m_pc);
        checkOutput({tag, ".pc_4"},  o_pc_4,     m_pc + 32'd4);
        checkOutput({tag, ".epc"},   o_epc,      m_epc);
        checkOutput({tag, ".exl"},   o_exl,      m_exl);
        checkOutput({tag, ".state"}, o_state,    m_mode);
        checkOutput({tag, ".fetch"}, o_fetch_en, (m_mode == 1));
        checkOutput({tag, ".fif"},   o_flush_if, e_fif);
        checkOutput({tag, ".fid"},   o_flush_id, e_fid);
        checkOutput({tag, ".fex"},   o_flush_ex, e_fex);
        checkOutput({tag, ".drop"},  o_exc_drop, e_drop);
        checkOutput({tag, ".rcnt"},  o_redirect_cnt, 0);
        checkOutput({tag, ".scnt"},  o_stall_cnt, 0);
    endtask

    // One clock cycle: drive at the falling edge, check mid-cycle, advance the model.
    task automatic runCycle(input stim_t s, input string tag);
        applyStimulus(s);
        #1;
        modelCycle(s);
        checkAll(tag);
        cap_fif  = o_flush_if;
        cap_fid  = o_flush_id;
        cap_fex  = o_flush_ex;
        cap_drop = o_exc_drop;
        @(posedge i_clk);
        modelCommit();
        @(negedge i_clk);
    endtask

    initial begin
        stim_t s;
        stim_t idle;
        logic [31:0] r;
        idle = '0;

        vecs[0]  = '{mk(0,0,0,0,0,0,0,26'h0,       32'h0,    32'h0),         32'h0000_000C, 1'b0};
        vecs[1]  = '{mk(0,1,0,1,0,0,0,26'hFFFE,    32'h0,    32'h100),       32'h0000_00F8, 1'b1};
        vecs[2]  = '{mk(1,1,0,1,0,0,0,26'hFFFE,    32'h0,    32'h100),       32'h0000_00F8, 1'b0};
        vecs[3]  = '{mk(0,0,0,0,0,0,0,26'h0,       32'h0,    32'h0),         32'h0000_00FC, 1'b0};
        vecs[4]  = '{mk(0,0,1,0,0,0,0,26'h0010,    32'h0,    32'h200),       32'h0000_0240, 1'b1};
        vecs[5]  = '{mk(0,1,0,0,0,0,0,26'h0010,    32'h0,    32'h200),       32'h0000_0244, 1'b0};
        vecs[6]  = '{mk(0,0,1,1,0,0,0,26'h0010,    32'h0,    32'h200),       32'h0000_0248, 1'b0};
        vecs[7]  = '{mk(0,0,0,0,1,0,0,26'h0123456, 32'h0,    32'hA000_0000), 32'hA048_D158, 1'b1};
        vecs[8]  = '{mk(0,0,0,0,0,1,0,26'h0,       32'h3000, 32'h0),         32'h0000_3000, 1'b1};
        vecs[9]  = '{mk(1,0,0,0,1,0,0,26'h1,       32'h0,    32'h0),         32'h0000_3000, 1'b0};
        vecs[10] = '{mk(0,0,0,0,1,1,0,26'h5,       32'h4000, 32'h0),         32'h0000_4000, 1'b1};
        vecs[11] = '{mk(0,1,0,1,1,0,0,26'h4,       32'h0,    32'h1000_0010), 32'h1000_0010, 1'b1};
        vecs[12] = '{mk(0,1,0,1,0,0,0,26'h0008,    32'h0,    32'hFFFF_FFF0), 32'h0000_0010, 1'b1};
        vecs[13] = '{mk(0,0,0,0,0,0,1,26'h0,       32'h0,    32'h0),         32'h0000_0014, 1'b0};

        // reset state
        applyStimulus(idle);
        i_rst_n = 1'b0;
        modelReset();
        #12;
        checkOutput("rst.pc",    o_pc, RESET_PC);
        checkOutput("rst.epc",   o_epc, 0);
        checkOutput("rst.exl",   o_exl, 0);
        checkOutput("rst.state", o_state, 0);
        checkOutput("rst.fetch", o_fetch_en, 0);
        checkOutput("rst.fif",   o_flush_if, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // boot then sequential fetch 0,4,8
        runCycle(idle, "boot");
        checkOutput("boot.pc0", o_pc, 32'h0);
        checkOutput("boot.fetch_on", o_fetch_en, 1);
        runCycle(idle, "seq1");
        checkOutput("seq.pc4", o_pc, 32'h4);
        runCycle(idle, "seq2");
        checkOutput("seq.pc8", o_pc, 32'h8);

        // directed redirect table
        for (int i = 0; i < 14; i++) begin
            runCycle(vecs[i].s, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.fif", i), cap_fif, vecs[i].exp_fif);
            checkOutput($sformatf("vec%0d.pc", i), o_pc, vecs[i].exp_pc);
        end

        // exception entry, drain, eret overriding a stall
        s = idle; s.exc_req = 1; s.exc_pc = 32'h2040; s.pc4dec = 32'h18;
        runCycle(s, "exc");
        checkOutput("exc.flush_all", {cap_fif, cap_fid, cap_fex}, 3'b111);
        checkOutput("exc.pc", o_pc, 32'hC);
        checkOutput("exc.epc", o_epc, 32'h2040);
        checkOutput("exc.exl", o_exl, 1);
        checkOutput("exc.fetch_off0", o_fetch_en, 0);
        runCycle(idle, "drain1");
        checkOutput("exc.fetch_off1", o_fetch_en, 0);
        runCycle(idle, "drain2");
        checkOutput("exc.fetch_back", o_fetch_en, 1);
        checkOutput("exc.handler_pc", o_pc, 32'hC);
        runCycle(idle, "hnd");
        s = idle; s.eret = 1; s.stall = 1;
        runCycle(s, "eret");
        checkOutput("eret.fif", cap_fif, 1);
        checkOutput("eret.pc", o_pc, 32'h2040);
        checkOutput("eret.exl", o_exl, 0);

        // nested exceptions dropped while EXL=1, then misaligned jr
        s = idle; s.exc_req = 1; s.exc_pc = 32'h3300;
        runCycle(s, "nest");
        s = idle; s.exc_req = 1; s.exc_pc = 32'h7777;
        runCycle(s, "nest.drain");
        checkOutput("nest.drain_drop", cap_drop, 1);
        checkOutput("nest.drain_epc", o_epc, 32'h3300);
        runCycle(idle, "nest.drain2");
        s = idle; s.exc_req = 1; s.exc_pc = 32'h8888; s.j = 1; s.imm26 = 26'h40;
        runCycle(s, "nest.run");
        checkOutput("nest.run_drop", cap_drop, 1);
        checkOutput("nest.run_epc", o_epc, 32'h3300);
        checkOutput("nest.run_jpc", o_pc, 32'h100);
        s = idle; s.eret = 1;
        runCycle(s, "nest.eret");
        checkOutput("nest.eret_pc", o_pc, 32'h3300);
        s = idle; s.jr = 1; s.rs = 32'h3002; s.pc4dec = 32'h804;
        runCycle(s, "jrbad");
        checkOutput("jrbad.flush_all", {cap_fif, cap_fid, cap_fex}, 3'b111);
        checkOutput("jrbad.epc", o_epc, 32'h800);
        checkOutput("jrbad.pc", o_pc, 32'hC);
        checkOutput("jrbad.exl", o_exl, 1);
        runCycle(idle, "jrbad.d1");
        runCycle(idle, "jrbad.d2");

        // soft reset wins over exception and jump; held, then released
        s = idle; s.s_rst = 1; s.exc_req = 1; s.exc_pc = 32'h9999; s.j = 1; s.imm26 = 26'h80;
        runCycle(s, "srst");
        checkOutput("srst.state", o_state, 3);
        checkOutput("srst.epc", o_epc, 32'h800);
        checkOutput("srst.pc_hold", o_pc, 32'hC);
        s = idle; s.s_rst = 1;
        runCycle(s, "srst.hold");
        checkOutput("srst.hold_flush", {cap_fif, cap_fid, cap_fex}, 3'b111);
        checkOutput("srst.hold_fetch", o_fetch_en, 0);
        runCycle(idle, "srst.rel");
        checkOutput("srst.rel_pc", o_pc, RESET_PC);
        checkOutput("srst.rel_state", o_state, 0);
        checkOutput("srst.rel_exl", o_exl, 0);
        checkOutput("srst.rel_epc", o_epc, 32'h800);
        runCycle(idle, "srst.boot");
        checkOutput("srst.run", o_state, 1);

        // asynchronous reset in the middle of a drain
        s = idle; s.exc_req = 1; s.exc_pc = 32'h4444;
        runCycle(s, "arst.exc");
        i_rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("arst.pc", o_pc, RESET_PC);
        checkOutput("arst.epc", o_epc, 0);
        checkOutput("arst.exl", o_exl, 0);
        checkOutput("arst.state", o_state, 0);
        checkOutput("arst.fetch", o_fetch_en, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        runCycle(idle, "arst.boot");

        // PC wrap-around
        s = idle; s.jr = 1; s.rs = 32'hFFFF_FFFC;
        runCycle(s, "wrap.jr");
        checkOutput("wrap.pc_4", o_pc_4, 32'h0);
        runCycle(idle, "wrap.seq");
        checkOutput("wrap.pc", o_pc, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            s         = '0;
            s.stall   = ($urandom_range(0, 4) == 0);
            s.s_rst   = ($urandom_range(0, 49) == 0);
            s.exc_req = ($urandom_range(0, 24) == 0);
            s.eret    = ($urandom_range(0, 14) == 0);
            s.jr      = ($urandom_range(0, 9) == 0);
            s.j       = ($urandom_range(0, 9) == 0);
            s.beq     = 1'($urandom_range(0, 1));
            s.bne     = 1'($urandom_range(0, 1));
            s.zero    = 1'($urandom_range(0, 1));
            s.imm26   = 26'($urandom);
            r         = $urandom;
            s.rs      = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
            s.pc4dec  = $urandom & 32'hFFFF_FFFC;
            s.exc_pc  = $urandom & 32'hFFFF_FFFC;
            runCycle(s, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Program-counter sequencer for the pipelined core. It owns the PC and EPC registers and the exception-level (EXL) flag. Each cycle it arbitrates among soft reset, exceptions, eret, jr, j, taken branches and sequential fetch, and drives pipeline flush and fetch-enable. It sits between the fetch stage and the decode/execute hazard logic, replacing a free-running next-PC mux with a stateful controller.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset and on soft-reset release
- EXC_VECTOR, 32'h0000_000C, PC loaded on exception entry
- EXC_DRAIN_CYC, 2, fetch-disabled cycles after exception entry (1..15)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  decode hazard stall; PC holds
- i_s_rst  in  1  synchronous soft-reset request, level
- i_beq, i_bne, i_zero, i_j, i_jr  in  1 each  decode-stage control
- i_imm26  in  26  decode-stage immediate field
- i_rs  in  32  jr target
- i_pc_4_dec  in  32  PC+4 of the decode-stage instruction
- i_exc_req  in  1  execute-stage exception request
- i_exc_pc  in  32  PC of the faulting instruction
- i_eret  in  1  decode-stage eret
- o_pc  out  32  fetch PC
- o_pc_4  out  32  o_pc+4, modulo 2^32
- o_fetch_en  out  1  instruction fetch valid
- o_flush_if, o_flush_id, o_flush_ex  out  1 each  squash pulses
- o_epc  out  32  exception PC
- o_exl  out  1  exception level
- o_exc_drop  out  1  pulse: exception ignored (EXL=1)
- o_state  out  2  BOOT=0, RUN=1, EXC_DRAIN=2, SRST=3

## Operation
- Reset values: o_pc=RESET_PC, o_epc=0, o_exl=0, o_state=BOOT, o_fetch_en=0, all flush and pulse outputs 0.
- BOOT: fetch disabled for one cycle, then RUN.
- RUN: the next PC is chosen by fixed priority:
  - i_s_rst: go to SRST.
  - Exception: i_exc_req, or a jr with i_rs[1:0]≠0. On a misaligned jr, EPC=i_pc_4_dec−4.
  - eret (only when o_exl=1).
  - jr
  - j: target = {i_pc_4_dec[31:28], i_imm26, 2'b00}.
  - Taken branch: (i_beq&i_zero)|(i_bne&~i_zero). Target = i_pc_4_dec + (sext(imm16)<<2), modulo 2^32.
  - Sequential: o_pc+4.
- i_stall holds the PC and suppresses jr, j and branch. Exception, eret and soft reset override stall.
- No delay slot. Any taken jr, j, branch or eret pulses o_flush_if for one cycle.
- Exception entry:
  - o_pc←EXC_VECTOR, o_epc←i_exc_pc, o_exl←1.
  - o_flush_if, o_flush_id and o_flush_ex pulse for one cycle.
  - Go to EXC_DRAIN.
- EXC_DRAIN: fetch disabled while a down-counter runs from EXC_DRAIN_CYC to 0, then RUN. i_exc_req in this state is ignored and pulses o_exc_drop.
- i_exc_req while o_exl=1 in RUN: dropped with an o_exc_drop pulse; the lower-priority redirect still proceeds.
- eret with o_exl=0: treated as a no-op; no flush.
- eret with o_exl=1: o_pc←o_epc, o_exl←0.
- SRST:
  - While i_s_rst=1: PC held, fetch disabled, all three flushes held at 1.
  - On release: o_pc←RESET_PC, o_exl←0, go to BOOT.
  - o_epc is preserved.
- Asynchronous reset mid-operation returns all state to reset values immediately.

## Timing
- All registered outputs change on the rising edge of i_clk.
- Redirect latency: control sampled in cycle N, new o_pc visible in cycle N+1.
- Flush pulses are combinational from the cycle-N decision, asserted during cycle N.
- Exception to first handler fetch: 1 + EXC_DRAIN_CYC cycles after the EXC_DRAIN entry edge.
- o_pc_4 is combinational from o_pc.

## Configuration
- PC_SEQ_PERF_EN defined: adds o_redirect_cnt (16-bit) and o_stall_cnt (16-bit).
  - Saturating counts of redirects and stall cycles.
  - Cleared by i_rst_n and by soft-reset release.
- Undefined: both ports exist but are tied to 0, and no counter registers are synthesised.

## Test plan
- Reset release, no control asserted → o_fetch_en=0 for one cycle, then o_pc 0,4,8,… each cycle.
- Branch: i_beq=1, i_zero=1, i_pc_4_dec=0x100, imm16=0xFFFE → next o_pc=0xF8, o_flush_if pulses once; same stimulus with i_stall=1 → o_pc unchanged.
- Exception and eret: i_exc_req with i_exc_pc=0x2040 → o_pc=0xC, o_epc=0x2040, o_exl=1, three flushes pulse, fetch off 2 cycles; later eret → o_pc=0x2040, o_exl=0.
- Nested exception, then jr with i_rs=0x3002 in RUN with o_exl=0:
  - i_exc_req while o_exl=1 → o_exc_drop pulses, o_epc unchanged.
  - jr → address-error entry, o_epc=i_pc_4_dec−4.
- Simultaneous i_s_rst, i_exc_req, i_j → SRST wins, o_epc unchanged; after release o_pc=RESET_PC, BOOT, then RUN.
- i_rst_n asserted during EXC_DRAIN → immediate return to reset values; wrap case o_pc=0xFFFF_FFFC sequential → 0x0000_0000.
